fifo_sync_asym: RTL and testbench

Single-clock FIFO with its own storage and an asymmetric aspect ratio. Write width and read width are independent parameters whose ratio is a power of two. It is the parametrised successor of the 18K TDP FIFO mode, for soft FIFOs and datapath buffering in fabric.
- Occupancy, almost-full/almost-empty flags, sticky overrun/underrun and synchronous flush are all handled internally.
- Storage and counting are in base words; BW = min(WR_W, RD_W).

---
 rtl/fifo_sync_pkg.sv | 47 ++++
 rtl/fifo_sync_ptr_ctl.sv | 79 +++++++
 rtl/fifo_sync_asym.sv | 135 +++++++++++++
 tb/tb_fifo_sync_asym.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sync_pkg.sv
// Shared helpers for the asymmetric synchronous FIFO: sizing functions,
// aspect-ratio legality check and the status flag bundle.
package fifo_sync_pkg;

    function automatic int clog2_f(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int min_f(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int max_f(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Legal aspect ratios are 1:1, 1:2 and 1:4 in either direction.
    function automatic bit ratio_ok_f(input int wr_w, input int rd_w);
        int bw;
        int ratio;
        bw    = min_f(wr_w, rd_w);
        ratio = max_f(wr_w, rd_w) / bw;
        return (bw > 0) && (max_f(wr_w, rd_w) % bw == 0) &&
               (ratio == 1 || ratio == 2 || ratio == 4);
    endfunction

    function automatic bit depth_ok_f(input int depth);
        return (depth >= 4) && ((depth & (depth - 1)) == 0);
    endfunction

    typedef struct packed {
        logic full;
        logic afull;
        logic overrun;
        logic empty;
        logic aempty;
        logic underrun;
    } flags_t;

endpackage

// File: rtl/fifo_sync_ptr_ctl.sv
// Pointer, occupancy and flag control for the asymmetric FIFO. Everything is
// counted in base words; flags are registered from the next occupancy.
module fifo_sync_ptr_ctl
    import fifo_sync_pkg::*;
#(
    parameter int DEPTH   = 2048,
    parameter int RATIO_W = 2,
    parameter int RATIO_R = 1,
    parameter int UPAE    = 16,
    parameter int UPAF    = 16,
    localparam int PW     = clog2_f(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wen,
    input  logic          ren,
    output logic [PW-1:0] wptr,
    output logic [PW-1:0] rptr,
    output logic          wr_acc,
    output logic          rd_acc,
    output logic [PW:0]   count,
    output flags_t        flags
);

    localparam int CW = PW + 1;
    localparam flags_t FLAGS_RST = flags_t'({1'b0, (UPAF >= DEPTH) ? 1'b1 : 1'b0,
                                             1'b0, 1'b1, 1'b1, 1'b0});

    logic [PW-1:0] wptr_reg, rptr_reg;
    logic [CW-1:0] count_reg, count_next, free_next;
    flags_t        flags_reg, flags_next;

    assign wr_acc = wen & ~flags_reg.full & ~flush;
    assign rd_acc = ren & ~flags_reg.empty & ~flush;

    always_comb begin
        count_next = count_reg;
        if (wr_acc) begin
            count_next = count_next + CW'(RATIO_W);
        end
        if (rd_acc) begin
            count_next = count_next - CW'(RATIO_R);
        end
        free_next           = CW'(DEPTH) - count_next;
        flags_next.full     = free_next < CW'(RATIO_W);
        flags_next.afull    = int'(free_next) <= UPAF;
        flags_next.empty    = count_next < CW'(RATIO_R);
        flags_next.aempty   = int'(count_next) <= UPAE;
        // Sticky errors look at the flags the request was judged against.
        flags_next.overrun  = flags_reg.overrun | (wen & flags_reg.full);
        flags_next.underrun = flags_reg.underrun | (ren & flags_reg.empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
            flags_reg <= FLAGS_RST;
        end else if (flush) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
            flags_reg <= FLAGS_RST;
        end else begin
            wptr_reg  <= wptr_reg + (wr_acc ? PW'(RATIO_W) : '0);
            rptr_reg  <= rptr_reg + (rd_acc ? PW'(RATIO_R) : '0);
            count_reg <= count_next;
            flags_reg <= flags_next;
        end
    end

    assign wptr  = wptr_reg;
    assign rptr  = rptr_reg;
    assign count = count_reg;
    assign flags = flags_reg;

endmodule

// File: rtl/fifo_sync_asym.sv
// Single-clock FIFO with independent write/read widths (ratio 1, 2 or 4).
// Define FIFO_SYNC_ASYM_FWFT_EN for first-word-fall-through read data.
module fifo_sync_asym
    import fifo_sync_pkg::*;
#(
    parameter int WR_W  = 18,
    parameter int RD_W  = 9,
    parameter int DEPTH = 2048,
    parameter int UPAE  = 16,
    parameter int UPAF  = 16
) (
    input  logic                      CLK_i,
    input  logic                      RST_i,
    input  logic                      FLUSH_i,
    input  logic                      WEN_i,
    input  logic [WR_W-1:0]           WDATA_i,
    input  logic                      REN_i,
    output logic [RD_W-1:0]           RDATA_o,
    output logic [clog2_f(DEPTH):0]   COUNT_o,
    output logic                      EMPTY_o,
    output logic                      AEMPTY_o,
    output logic                      FULL_o,
    output logic                      AFULL_o,
    output logic                      OVERRUN_o,
    output logic                      UNDERRUN_o
);

    localparam int BW      = min_f(WR_W, RD_W);
    localparam int RATIO_W = WR_W / BW;
    localparam int RATIO_R = RD_W / BW;
    localparam int LANES   = max_f(RATIO_W, RATIO_R);
    localparam int LB      = clog2_f(LANES);
    localparam int LBW     = (LB > 0) ? LB : 1;
    localparam int ROWS    = DEPTH / LANES;
    localparam int RB      = (clog2_f(ROWS) > 0) ? clog2_f(ROWS) : 1;
    localparam int PW      = clog2_f(DEPTH);

    if (!ratio_ok_f(WR_W, RD_W)) begin : g_bad_ratio
        $error("fifo_sync_asym: max(WR_W,RD_W)/min(WR_W,RD_W) must be 1, 2 or 4");
    end
    if (!depth_ok_f(DEPTH)) begin : g_bad_depth
        $error("fifo_sync_asym: DEPTH must be a power of two and at least 4");
    end

    logic [PW-1:0]       wptr, rptr;
    logic                wr_acc, rd_acc;
    logic [PW:0]         count;
    flags_t              flags;
    logic [RB-1:0]       wrow, rrow;
    logic [LBW-1:0]      wlane, rlane;
    logic [LANES*BW-1:0] lane_rd;
    logic [RD_W-1:0]     head;

    fifo_sync_ptr_ctl #(
        .DEPTH   (DEPTH),
        .RATIO_W (RATIO_W),
        .RATIO_R (RATIO_R),
        .UPAE    (UPAE),
        .UPAF    (UPAF)
    ) u_ptr_ctl (
        .clk    (CLK_i),
        .rst    (RST_i),
        .flush  (FLUSH_i),
        .wen    (WEN_i),
        .ren    (REN_i),
        .wptr   (wptr),
        .rptr   (rptr),
        .wr_acc (wr_acc),
        .rd_acc (rd_acc),
        .count  (count),
        .flags  (flags)
    );

    // Storage is split into LANES banks of base words; the wide side always
    // touches a whole row, the narrow side one bank of it.
    assign wrow  = RB'(wptr >> LB);
    assign rrow  = RB'(rptr >> LB);
    assign wlane = LBW'(wptr % LANES);
    assign rlane = LBW'(rptr % LANES);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [BW-1:0] mem [0:ROWS-1];
        logic          lane_we;
        logic [BW-1:0] lane_wd;

        if (RATIO_W == LANES) begin : g_wide_wr
            assign lane_we = wr_acc;
            assign lane_wd = WDATA_i[gi*BW +: BW];
        end else begin : g_narrow_wr
            assign lane_we = wr_acc & (wlane == LBW'(gi));
            assign lane_wd = WDATA_i[BW-1:0];
        end

        always_ff @(posedge CLK_i) begin
            if (lane_we) begin
                mem[wrow] <= lane_wd;
            end
        end

        assign lane_rd[gi*BW +: BW] = mem[rrow];
    end

    if (RATIO_R == LANES) begin : g_wide_rd
        assign head = lane_rd;
    end else begin : g_narrow_rd
        assign head = lane_rd[rlane*BW +: BW];
    end

`ifdef FIFO_SYNC_ASYM_FWFT_EN
    assign RDATA_o = flags.empty ? '0 : head;
`else
    logic [RD_W-1:0] rdata_reg;

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            rdata_reg <= '0;
        end else if (FLUSH_i) begin
            rdata_reg <= '0;
        end else if (rd_acc) begin
            rdata_reg <= head;
        end
    end

    assign RDATA_o = rdata_reg;
`endif

    assign COUNT_o    = count;
    assign EMPTY_o    = flags.empty;
    assign AEMPTY_o   = flags.aempty;
    assign FULL_o     = flags.full;
    assign AFULL_o    = flags.afull;
    assign OVERRUN_o  = flags.overrun;
    assign UNDERRUN_o = flags.underrun;

endmodule

// File: tb/tb_fifo_sync_asym.sv
// Randomised self-checking bench: a default 18->9 FIFO and a 9->36 DEPTH=16
// FIFO, both compared every cycle against queue-based reference models.
module tb_fifo_sync_asym;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // Instance 0: defaults (18 -> 9, DEPTH 2048, UPAE/UPAF 16)
    logic        flush0, wen0, ren0;
    logic [17:0] wdata0;
    logic [8:0]  rdata0;
    logic [11:0] count0;
    logic        empty0, aempty0, full0, afull0, ovr0, unr0;

    // Instance 1: 9 -> 36, DEPTH 16, UPAE/UPAF 4
    logic        flush1, wen1, ren1;
    logic [8:0]  wdata1;
    logic [35:0] rdata1;
    logic [4:0]  count1;
    logic        empty1, aempty1, full1, afull1, ovr1, unr1;

    fifo_sync_asym u_dut0 (
        .CLK_i(clk), .RST_i(rst), .FLUSH_i(flush0), .WEN_i(wen0), .WDATA_i(wdata0),
        .REN_i(ren0), .RDATA_o(rdata0), .COUNT_o(count0), .EMPTY_o(empty0),
        .AEMPTY_o(aempty0), .FULL_o(full0), .AFULL_o(afull0),
        .OVERRUN_o(ovr0), .UNDERRUN_o(unr0)
    );

    fifo_sync_asym #(.WR_W(9), .RD_W(36), .DEPTH(16), .UPAE(4), .UPAF(4)) u_dut1 (
        .CLK_i(clk), .RST_i(rst), .FLUSH_i(flush1), .WEN_i(wen1), .WDATA_i(wdata1),
        .REN_i(ren1), .RDATA_o(rdata1), .COUNT_o(count1), .EMPTY_o(empty1),
        .AEMPTY_o(aempty1), .FULL_o(full1), .AFULL_o(afull1),
        .OVERRUN_o(ovr1), .UNDERRUN_o(unr1)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: queues of 9-bit base words plus sticky bits and last read.
    bit [8:0]  q0[$];
    bit [8:0]  q1[$];
    bit        m_ov0, m_un0, m_ov1, m_un1;
    bit [8:0]  m_rd0;
    bit [35:0] m_rd1;

    function automatic logic [17:0] exp_status0();
        int c = q0.size();
        return {12'(c), c < 1, c <= 16, (2048 - c) < 2, (2048 - c) <= 16, m_ov0, m_un0};
    endfunction

    function automatic logic [17:0] got_status0();
        return {count0, empty0, aempty0, full0, afull0, ovr0, unr0};
    endfunction

    function automatic logic [10:0] exp_status1();
        int c = q1.size();
        return {5'(c), c < 4, c <= 4, (16 - c) < 1, (16 - c) <= 4, m_ov1, m_un1};
    endfunction

    function automatic logic [10:0] got_status1();
        return {count1, empty1, aempty1, full1, afull1, ovr1, unr1};
    endfunction

    function automatic logic [8:0] exp_rdata0();
`ifdef FIFO_SYNC_ASYM_FWFT_EN
        return (q0.size() >= 1) ? q0[0] : 9'd0;
`else
        return m_rd0;
`endif
    endfunction

    function automatic logic [35:0] exp_rdata1();
`ifdef FIFO_SYNC_ASYM_FWFT_EN
        return (q1.size() >= 4) ? {q1[3], q1[2], q1[1], q1[0]} : 36'd0;
`else
        return m_rd1;
`endif
    endfunction

    task automatic model_reset();
        q0.delete(); q1.delete();
        m_ov0 = 0; m_un0 = 0; m_ov1 = 0; m_un1 = 0;
        m_rd0 = '0; m_rd1 = '0;
    endtask

    // Apply the FIFO rules to the inputs about to be sampled on the next edge.
    task automatic model_update();
        int  c0 = q0.size();
        int  c1 = q1.size();
        bit  f0 = (2048 - c0) < 2, e0 = c0 < 1;
        bit  f1 = (16 - c1) < 1,   e1 = c1 < 4;
        if (flush0) begin
            q0.delete(); m_ov0 = 0; m_un0 = 0; m_rd0 = '0;
        end else begin
            if (wen0 && f0) m_ov0 = 1;
            if (ren0 && e0) m_un0 = 1;
            if (ren0 && !e0) m_rd0 = q0.pop_front();
            if (wen0 && !f0) begin
                q0.push_back(wdata0[8:0]);
                q0.push_back(wdata0[17:9]);
            end
        end
        if (flush1) begin
            q1.delete(); m_ov1 = 0; m_un1 = 0; m_rd1 = '0;
        end else begin
            if (wen1 && f1) m_ov1 = 1;
            if (ren1 && e1) m_un1 = 1;
            if (ren1 && !e1) begin
                for (int k = 0; k < 4; k++) m_rd1[k*9 +: 9] = q1.pop_front();
            end
            if (wen1 && !f1) q1.push_back(wdata1);
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush0 = 0; wen0 = 0; ren0 = 0; wdata0 = '0;
        flush1 = 0; wen1 = 0; ren1 = 0; wdata1 = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        if (got_status0() !== exp_status0()) begin
            errors++; $display("FAIL reset_status0 got %h expected %h", got_status0(), exp_status0());
        end
        checks++;
        if (got_status1() !== exp_status1()) begin
            errors++; $display("FAIL reset_status1 got %h expected %h", got_status1(), exp_status1());
        end
        checks++;
        if (rdata0 !== 9'd0 || rdata1 !== 36'd0) begin
            errors++; $display("FAIL reset_rdata got %h/%h expected 0/0", rdata0, rdata1);
        end
        checks++;
        rst = 0;
        step();
    endtask

    task automatic test_basic();
        wen0 = 1; wdata0 = 18'h30155;
        step();
        wen0 = 0; ren0 = 1;
        for (int i = 0; i < 3; i++) begin
            if (got_status0() !== exp_status0()) begin
                errors++; $display("FAIL basic_status[%0d] got %h expected %h", i, got_status0(), exp_status0());
            end
            checks++;
            if (rdata0 !== exp_rdata0()) begin
                errors++; $display("FAIL basic_rdata[%0d] got %h expected %h", i, rdata0, exp_rdata0());
            end
            checks++;
            if (i == 1) ren0 = 0;
            if (i < 2) step();
        end
    endtask

    task automatic test_fill_drain();
        wen0 = 1;
        for (int i = 0; i < 1026; i++) begin
            wdata0 = 18'($urandom);
            if (i == 1025) ren0 = 1;   // full with simultaneous write and read
            step();
            if (got_status0() !== exp_status0()) begin
                errors++; $display("FAIL fill_status[%0d] got %h expected %h", i, got_status0(), exp_status0());
            end
            checks++;
        end
        wen0 = 0; ren0 = 1;
        for (int i = 0; i < 2050; i++) begin
            step();
            if (got_status0() !== exp_status0() || rdata0 !== exp_rdata0()) begin
                errors++; $display("FAIL drain[%0d] got %h/%h expected %h/%h", i,
                                   got_status0(), rdata0, exp_status0(), exp_rdata0());
            end
            checks++;
        end
        ren0 = 0; flush0 = 1;
        step();
        flush0 = 0; wen0 = 1; ren0 = 1; wdata0 = 18'h2A5C3;   // empty with write and read
        step();
        wen0 = 0; ren0 = 0;
        if (got_status0() !== exp_status0()) begin
            errors++; $display("FAIL empty_wr_rd got %h expected %h", got_status0(), exp_status0());
        end
        checks++;
        flush0 = 1;
        step();
        flush0 = 0;
    endtask

    task automatic test_underrun();
        wen0 = 1; wdata0 = 18'h1F0AB;
        step();
        wen0 = 0; ren0 = 1;
        repeat (3) step();   // two good reads, then one while empty
        ren0 = 0;
        if (got_status0() !== exp_status0() || rdata0 !== exp_rdata0()) begin
            errors++; $display("FAIL underrun got %h/%h expected %h/%h",
                               got_status0(), rdata0, exp_status0(), exp_rdata0());
        end
        checks++;
        flush0 = 1;
        step();
        flush0 = 0;
        if (got_status0() !== exp_status0() || rdata0 !== exp_rdata0()) begin
            errors++; $display("FAIL underrun_flush got %h/%h expected %h/%h",
                               got_status0(), rdata0, exp_status0(), exp_rdata0());
        end
        checks++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            int wp = ((i / 250) % 2 == 0) ? 80 : 25;
            wen0   = ($urandom_range(99) < wp);
            ren0   = ($urandom_range(99) < 50);
            flush0 = ($urandom_range(199) == 0);
            wdata0 = 18'($urandom);
            step();
            if (got_status0() !== exp_status0() || rdata0 !== exp_rdata0()) begin
                errors++; $display("FAIL random[%0d] got %h/%h expected %h/%h", i,
                                   got_status0(), rdata0, exp_status0(), exp_rdata0());
            end
            checks++;
        end
        idle();
        flush0 = 1;
        step();
        flush0 = 0;
    endtask

    task automatic test_narrow_wide();
        flush1 = 1;
        step();
        flush1 = 0;
        for (int i = 1; i <= 4; i++) begin
            wen1 = 1; wdata1 = 9'(i);
            step();
            if (got_status1() !== exp_status1()) begin
                errors++; $display("FAIL nw_write[%0d] got %h expected %h", i, got_status1(), exp_status1());
            end
            checks++;
        end
        wen1 = 0; ren1 = 1;
        step();
        ren1 = 0;
        if (got_status1() !== exp_status1() || rdata1 !== exp_rdata1()) begin
            errors++; $display("FAIL nw_read got %h/%h expected %h/%h",
                               got_status1(), rdata1, exp_status1(), exp_rdata1());
        end
        checks++;
        for (int i = 0; i < 400; i++) begin
            wen1   = ($urandom_range(99) < 70);
            ren1   = ($urandom_range(99) < 30);
            wdata1 = 9'($urandom);
            step();
            if (got_status1() !== exp_status1() || rdata1 !== exp_rdata1()) begin
                errors++; $display("FAIL nw_random[%0d] got %h/%h expected %h/%h", i,
                                   got_status1(), rdata1, exp_status1(), exp_rdata1());
            end
            checks++;
        end
        idle();
    endtask

    task automatic test_async_reset();
        wen0 = 1; wen1 = 1;
        for (int i = 0; i < 5; i++) begin
            wdata0 = 18'($urandom); wdata1 = 9'($urandom);
            ren0 = (i == 3); ren1 = (i == 4);
            step();
        end
        idle();
        #3 rst = 1;
        #1;
        model_reset();
        if (got_status0() !== exp_status0() || rdata0 !== 9'd0) begin
            errors++; $display("FAIL async_rst0 got %h/%h expected %h/0", got_status0(), rdata0, exp_status0());
        end
        checks++;
        if (got_status1() !== exp_status1() || rdata1 !== 36'd0) begin
            errors++; $display("FAIL async_rst1 got %h/%h expected %h/0", got_status1(), rdata1, exp_status1());
        end
        checks++;
        #1 rst = 0;
        wen0 = 1; wdata0 = 18'h0B7E4;
        step();
        wen0 = 0;
        step();
        if (got_status0() !== exp_status0() || rdata0 !== exp_rdata0()) begin
            errors++; $display("FAIL post_rst_write got %h/%h expected %h/%h",
                               got_status0(), rdata0, exp_status0(), exp_rdata0());
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_drain();
        test_underrun();
        test_random();
        test_narrow_wide();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
